// File: rtl/sdram_cmd_scheduler.sv
// SDRAM command scheduler: arbitrates refresh/write/read after init and issues
// timed ACTIVE/READ/WRITE/PRECHARGE/AUTO REFRESH sequences with data strobes.
module sdram_cmd_scheduler #(
  parameter int BANK_WIDTH   = 2,
  parameter int ROW_WIDTH    = 11,
  parameter int COLUMN_WIDTH = 9,
  parameter int CAS_LATENCY  = 2,
  parameter int BURST_LENGTH = 4,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int T_WR         = 2,
  parameter int TIMER_WIDTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         sdram_init_done,
  input  logic                                         sdram_refresh_req,
  output logic                                         sdram_refresh_ack,
  input  logic [BANK_WIDTH+ROW_WIDTH+COLUMN_WIDTH-1:0] sdram_addr,
  input  logic                                         sdram_write_req,
  input  logic                                         sdram_read_req,
  output logic                                         sdram_outside_order_ack,
  output logic                                         sdram_busy,
  output logic                                         sdram_write_data_en,
  output logic                                         sdram_data_valid,
  output logic                                         sdram_data_bus_mode,
  output logic                                         sdram_cs_n,
  output logic                                         sdram_ras_n,
  output logic                                         sdram_cas_n,
  output logic                                         sdram_we_n,
  output logic [BANK_WIDTH-1:0]                        sdram_ba,
  output logic [ROW_WIDTH-1:0]                         sdram_a
);

  localparam int AW = BANK_WIDTH + ROW_WIDTH + COLUMN_WIDTH;

  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;

  // Timer reload values; each state counts down to 0 and acts in its last cycle.
  // The state register runs one cycle ahead of the registered command pins.
  localparam logic [TIMER_WIDTH-1:0] TMR_RCD   = TIMER_WIDTH'(T_RCD - 1);
  localparam logic [TIMER_WIDTH-1:0] TMR_RFC   = TIMER_WIDTH'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [TIMER_WIDTH-1:0] TMR_RP    = TIMER_WIDTH'((T_RP > 1) ? T_RP - 2 : 0);
  localparam logic [TIMER_WIDTH-1:0] TMR_BURST = TIMER_WIDTH'((BURST_LENGTH > 1) ? BURST_LENGTH - 2 : 0);
  localparam logic [TIMER_WIDTH-1:0] TMR_WR    = TIMER_WIDTH'(T_WR);
  localparam logic [TIMER_WIDTH-1:0] TMR_RD    = TIMER_WIDTH'(CAS_LATENCY + BURST_LENGTH - 1);
  localparam logic [TIMER_WIDTH-1:0] TMR_BL    = TIMER_WIDTH'(BURST_LENGTH);

  typedef enum logic [2:0] {
    IDLE,
    REFRESH_WAIT,
    RCD_WAIT,
    WRITE_BURST,
    WR_RECOVER,
    READ_WAIT,
    PRECHARGE_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
  logic [3:0]              cmd_q, cmd_d;
  logic [BANK_WIDTH-1:0]   ba_q, ba_d;
  logic [ROW_WIDTH-1:0]    a_q, a_d;
  logic [BANK_WIDTH-1:0]   bank_q, bank_d;
  logic [COLUMN_WIDTH-1:0] col_q, col_d;
  logic                    is_write_q, is_write_d;
  logic                    refresh_ack_q, refresh_ack_d;
  logic                    oo_ack_q, oo_ack_d;
  logic                    busy_q, busy_d;
  logic                    wr_en_q, wr_en_d;
  logic                    valid_q, valid_d;
  logic                    bus_mode_q, bus_mode_d;
  logic                    issue_pre;

  logic [BANK_WIDTH-1:0]   req_bank;
  logic [ROW_WIDTH-1:0]    req_row;
  logic [COLUMN_WIDTH-1:0] req_col;

  assign req_bank = sdram_addr[AW-1 -: BANK_WIDTH];
  assign req_row  = sdram_addr[COLUMN_WIDTH +: ROW_WIDTH];
  assign req_col  = sdram_addr[COLUMN_WIDTH-1:0];

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    cmd_d         = CMD_NOP;
    ba_d          = ba_q;
    a_d           = a_q;
    bank_d        = bank_q;
    col_d         = col_q;
    is_write_d    = is_write_q;
    refresh_ack_d = 1'b0;
    oo_ack_d      = 1'b0;
    wr_en_d       = 1'b0;
    valid_d       = 1'b0;
    bus_mode_d    = 1'b0;
    issue_pre     = 1'b0;
    busy_d        = (state_q != IDLE) || !sdram_init_done;

    case (state_q)
      IDLE: begin
        // The ack guard stops a still-held refresh request from being taken twice.
        if (sdram_init_done && !refresh_ack_q) begin
          if (sdram_refresh_req) begin
            cmd_d         = CMD_AREF;
            refresh_ack_d = 1'b1;
            timer_d       = TMR_RFC;
            state_d       = (T_RFC > 1) ? REFRESH_WAIT : IDLE;
          end else if (sdram_write_req || sdram_read_req) begin
            cmd_d      = CMD_ACT;
            oo_ack_d   = 1'b1;
            ba_d       = req_bank;
            a_d        = req_row;
            bank_d     = req_bank;
            col_d      = req_col;
            is_write_d = sdram_write_req;
            timer_d    = TMR_RCD;
            state_d    = RCD_WAIT;
          end
        end
      end
      REFRESH_WAIT, PRECHARGE_WAIT: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      RCD_WAIT: begin
        if (timer_q == '0) begin
          ba_d = bank_q;
          a_d  = '0;
          a_d[COLUMN_WIDTH-1:0] = col_q;
          if (is_write_q) begin
            cmd_d      = CMD_WRITE;
            wr_en_d    = 1'b1;
            bus_mode_d = 1'b1;
            if (BURST_LENGTH > 1) begin
              state_d = WRITE_BURST;
              timer_d = TMR_BURST;
            end else begin
              state_d = WR_RECOVER;
              timer_d = TMR_WR;
            end
          end else begin
            cmd_d   = CMD_READ;
            state_d = READ_WAIT;
            timer_d = TMR_RD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      WRITE_BURST: begin
        wr_en_d    = 1'b1;
        bus_mode_d = 1'b1;
        if (timer_q == '0) begin
          state_d = WR_RECOVER;
          timer_d = TMR_WR;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      WR_RECOVER: begin
        if (timer_q == '0) issue_pre = 1'b1;
        else               timer_d   = timer_q - 1'b1;
      end
      READ_WAIT: begin
        // Beats land on the pins one cycle after this decision.
        valid_d = (timer_q != '0) && (timer_q <= TMR_BL);
        if (timer_q == '0) issue_pre = 1'b1;
        else               timer_d   = timer_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (issue_pre) begin
      cmd_d     = CMD_PRE;
      a_d       = '0;
      a_d[10]   = 1'b1;
      timer_d   = TMR_RP;
      state_d   = (T_RP > 1) ? PRECHARGE_WAIT : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      cmd_q         <= CMD_DESEL;
      ba_q          <= '0;
      a_q           <= '0;
      bank_q        <= '0;
      col_q         <= '0;
      is_write_q    <= 1'b0;
      refresh_ack_q <= 1'b0;
      oo_ack_q      <= 1'b0;
      busy_q        <= 1'b1;
      wr_en_q       <= 1'b0;
      valid_q       <= 1'b0;
      bus_mode_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      cmd_q         <= cmd_d;
      ba_q          <= ba_d;
      a_q           <= a_d;
      bank_q        <= bank_d;
      col_q         <= col_d;
      is_write_q    <= is_write_d;
      refresh_ack_q <= refresh_ack_d;
      oo_ack_q      <= oo_ack_d;
      busy_q        <= busy_d;
      wr_en_q       <= wr_en_d;
      valid_q       <= valid_d;
      bus_mode_q    <= bus_mode_d;
    end
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_ba                = ba_q;
  assign sdram_a                 = a_q;
  assign sdram_refresh_ack       = refresh_ack_q;
  assign sdram_outside_order_ack = oo_ack_q;
  assign sdram_busy              = busy_q;
  assign sdram_write_data_en     = wr_en_q;
  assign sdram_data_valid        = valid_q;
  assign sdram_data_bus_mode     = bus_mode_q;

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Scoreboard bench: expected commands queued at stimulus, popped as the DUT issues them.
module tb_sdram_cmd_scheduler;

  localparam int CL = 2, BL = 4, RCD = 2, RP = 2, RFC = 7, WR = 2;
  localparam logic [3:0] NOP = 4'b0111, DES = 4'b1111, ACT = 4'b0011, RD = 4'b0101,
                         WRC = 4'b0100, PRE = 4'b0010, AREF = 4'b0001;

  logic clk = 1'b0, rst_n = 1'b0;
  logic init_done = 1'b0, refresh_req = 1'b0, write_req = 1'b0, read_req = 1'b0;
  logic [21:0] addr = '0;
  logic refresh_ack, oo_ack, busy, wr_en, data_valid, bus_mode;
  logic cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [10:0] a;

  logic read8 = 1'b0;
  logic [21:0] addr8 = '0;
  logic rack8, ack8, busy8, wen8, valid8, bm8, cs8, ras8, cas8, we8;
  logic [1:0]  ba8;
  logic [10:0] a8;

  always #5 clk = ~clk;

  sdram_cmd_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init_done),
    .sdram_refresh_req(refresh_req), .sdram_refresh_ack(refresh_ack),
    .sdram_addr(addr), .sdram_write_req(write_req), .sdram_read_req(read_req),
    .sdram_outside_order_ack(oo_ack), .sdram_busy(busy),
    .sdram_write_data_en(wr_en), .sdram_data_valid(data_valid),
    .sdram_data_bus_mode(bus_mode), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
    .sdram_cas_n(cas_n), .sdram_we_n(we_n), .sdram_ba(ba), .sdram_a(a)
  );

  sdram_cmd_scheduler #(.CAS_LATENCY(3), .BURST_LENGTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(1'b1),
    .sdram_refresh_req(1'b0), .sdram_refresh_ack(rack8),
    .sdram_addr(addr8), .sdram_write_req(1'b0), .sdram_read_req(read8),
    .sdram_outside_order_ack(ack8), .sdram_busy(busy8),
    .sdram_write_data_en(wen8), .sdram_data_valid(valid8),
    .sdram_data_bus_mode(bm8), .sdram_cs_n(cs8), .sdram_ras_n(ras8),
    .sdram_cas_n(cas8), .sdram_we_n(we8), .sdram_ba(ba8), .sdram_a(a8)
  );

  typedef struct {
    logic [3:0] cmd;
    int ba;    // -1: don't check
    int a;
    int amask;
    int gap;   // cycles since previous command, -1: don't check
    int at;    // absolute cycle, -1: don't check
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, last_cmd = 0;
  int wr_lo = -1, wr_hi = -1, rd_lo = -1, rd_hi = -1;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic void push(input logic [3:0] c, input int b, input int av,
                               input int m, input int g, input int t);
    exp_t e;
    e.cmd = c; e.ba = b; e.a = av; e.amask = m; e.gap = g; e.at = t;
    exp_q.push_back(e);
  endfunction

  function automatic void push_access(input bit wr, input int b, input int row,
                                      input int col, input int gap_act, input int at_act);
    push(ACT, b, row, 'h7FF, gap_act, at_act);
    push(wr ? WRC : RD, b, col, 'h7FF, RCD, -1);
    push(PRE, -1, 'h400, 'h400, wr ? BL + WR : CL + BL, -1);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Command/strobe monitor on the opposite edge.
  always @(negedge clk) begin
    logic [3:0] c;
    exp_t e;
    c = {cs_n, ras_n, cas_n, we_n};
    if (!rst_n) begin
      wr_lo = -1; wr_hi = -1; rd_lo = -1; rd_hi = -1;
    end else begin
      if (c != NOP && c != DES) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_cmd", c, NOP);
        end else begin
          e = exp_q.pop_front();
          chk("cmd", c, e.cmd);
          if (e.ba >= 0) chk("ba", ba, e.ba);
          chk("a", a & e.amask, e.a);
          if (e.gap >= 0) chk("cmd_gap", cyc - last_cmd, e.gap);
          if (e.at >= 0)  chk("cmd_cycle", cyc, e.at);
        end
        last_cmd = cyc;
        if (c == WRC) begin wr_lo = cyc; wr_hi = cyc + BL - 1; end
        if (c == RD)  begin rd_lo = cyc + CL; rd_hi = cyc + CL + BL - 1; end
      end
      chk("write_data_en", wr_en, int'(cyc >= wr_lo && cyc <= wr_hi));
      chk("bus_mode", bus_mode, int'(cyc >= wr_lo && cyc <= wr_hi));
      chk("data_valid", data_valid, int'(cyc >= rd_lo && cyc <= rd_hi));
      chk("refresh_ack", refresh_ack, int'(c == AREF));
      chk("order_ack", oo_ack, int'(c == ACT));
    end
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 300 && exp_q.size() != 0; k++) step();
    if (exp_q.size() != 0) begin
      chk("queue_drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic busy_tail();
    // Called in the PRECHARGE cycle: still busy one cycle later, idle two later.
    step(); chk("busy_after_pre1", busy, 1);
    step(); chk("busy_after_pre2", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tr, fv, nv, pre, bm;
    bit raised;
    logic [3:0] c8;

    // Reset values
    step();
    chk("rst_cmd", {cs_n, ras_n, cas_n, we_n}, DES);
    chk("rst_ba", ba, 0);
    chk("rst_a", a, 0);
    chk("rst_busy", busy, 1);
    chk("rst_strobes", {wr_en, data_valid, bus_mode, refresh_ack, oo_ack}, 0);
    rst_n = 1'b1;

    // Init low holds everything off
    addr = {2'd2, 11'h155, 9'h0A3};
    write_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("busy_init_low", busy, 1);
    end
    push_access(1, 2, 'h155, 'h0A3, -1, cyc + 1);
    init_done = 1'b1;
    for (int i = 0; i < 20 && write_req; i++) begin
      step();
      if (oo_ack) begin write_req = 1'b0; addr = '1; end
    end
    chk("write_ack_seen", write_req, 0);
    wait_done();
    busy_tail();

    // Single read at the extremes of row and column
    addr = {2'd1, 11'h7FF, 9'h1FF};
    read_req = 1'b1;
    push_access(0, 1, 'h7FF, 'h1FF, -1, cyc + 1);
    for (int i = 0; i < 20 && read_req; i++) begin
      step();
      if (oo_ack) begin read_req = 1'b0; addr = '0; end
    end
    chk("read_ack_seen", read_req, 0);
    wait_done();
    busy_tail();

    // Refresh, write and read all at once: refresh > write > read
    repeat (3) step();
    addr = {2'd3, 11'h0AA, 9'h055};
    refresh_req = 1'b1; write_req = 1'b1; read_req = 1'b1;
    push(AREF, -1, 0, 0, -1, cyc + 1);
    push_access(1, 3, 'h0AA, 'h055, RFC, -1);
    push_access(0, 0, 'h123, 'h044, RP, -1);
    for (int i = 0; i < 200 && (refresh_req || write_req || read_req); i++) begin
      step();
      if (refresh_ack) refresh_req = 1'b0;
      if (oo_ack) begin
        if (write_req) begin write_req = 1'b0; addr = {2'd0, 11'h123, 9'h044}; end
        else read_req = 1'b0;
      end
    end
    chk("triple_acks_seen", {refresh_req, write_req, read_req}, 0);
    wait_done();

    // Refresh raised mid-read waits for the access to finish
    repeat (2) step();
    addr = {2'd2, 11'h001, 9'h100};
    read_req = 1'b1;
    raised = 1'b0;
    push_access(0, 2, 'h001, 'h100, -1, cyc + 1);
    push(AREF, -1, 0, 0, RP, -1);
    for (int i = 0; i < 100 && (read_req || refresh_req || !raised); i++) begin
      step();
      if (oo_ack) read_req = 1'b0;
      if (refresh_ack) refresh_req = 1'b0;
      if (data_valid && !raised) begin refresh_req = 1'b1; raised = 1'b1; end
    end
    chk("midread_refresh_done", {raised, refresh_req}, 2'b10);
    wait_done();

    // Reset during a write burst
    repeat (RFC) step();
    addr = {2'd1, 11'h010, 9'h020};
    write_req = 1'b1;
    push_access(1, 1, 'h010, 'h020, -1, cyc + 1);
    for (int i = 0; i < 30 && !wr_en; i++) begin
      step();
      if (oo_ack) write_req = 1'b0;
    end
    chk("burst_reached", wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_cmd", {cs_n, ras_n, cas_n, we_n}, DES);
    chk("async_rst_wr_en", wr_en, 0);
    chk("async_rst_bus_mode", bus_mode, 0);
    chk("async_rst_busy", busy, 1);
    chk("async_rst_addr", {ba, a}, 0);
    exp_q.delete();
    step();
    chk("rst_held_wr_en", wr_en, 0);
    step();
    rst_n = 1'b1;
    addr = {2'd0, 11'h300, 9'h1F0};
    write_req = 1'b1;
    push_access(1, 0, 'h300, 'h1F0, -1, cyc + 1);
    for (int i = 0; i < 20 && write_req; i++) begin
      step();
      if (oo_ack) write_req = 1'b0;
    end
    chk("post_rst_ack_seen", write_req, 0);
    wait_done();
    busy_tail();

    // CL=3 / BL=8 instance
    addr8 = {2'd3, 11'h0F0, 9'h011};
    read8 = 1'b1;
    tr = -1; fv = -1; nv = 0; pre = -1; bm = 0;
    for (int i = 0; i < 100 && pre < 0; i++) begin
      step();
      if (ack8) read8 = 1'b0;
      c8 = {cs8, ras8, cas8, we8};
      if (c8 == RD) tr = cyc;
      if (valid8) begin if (fv < 0) fv = cyc; nv++; end
      if (bm8) bm = 1;
      if (c8 == PRE) pre = cyc;
    end
    chk("cl3_first_beat", fv - tr, 3);
    chk("bl8_beats", nv, 8);
    chk("cl3_bl8_pre_gap", pre - tr, 11);
    chk("cl3_bus_mode", bm, 0);
    chk("cl3_col", (tr >= 0) ? 1 : 0, 1);

    repeat (3) step();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
